control_in_driver_rtl: RTL and testbench

- Synthesizable transmitter for the LC3 control_in interface.
- Takes transaction records on a valid/ready port, buffers them, and drives complete_data, complete_instr, IR, NZP, psr, IR_Exec and IMem_dout cycle-accurately.
- Each record is held on the bus for a programmable number of cycles.
- Used as an emulation-side stimulus source, in place of a behavioural driver, opposite the control_in monitor.

---
 rtl/control_in_drv_pkg.sv | 32 +++
 rtl/control_in_drv_fifo.sv | 66 ++++++
 rtl/control_in_driver_rtl.sv | 173 +++++++++++++++++
 tb/tb_control_in_driver_rtl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_in_drv_pkg.sv
// ---------------------------------------------------------------------------
// control_in_drv_pkg
// Shared types for the LC3 control_in transmitter: the record carried
// through the input FIFO and the driver state encoding.
// ---------------------------------------------------------------------------
package control_in_drv_pkg;

    localparam int IR_W       = 16;
    localparam int NZP_W      = 3;
    localparam int PSR_W      = 3;
    // Storage width of the hold field inside a buffered record. The top
    // zero-extends its HOLD_W-bit in_hold into this field, so HOLD_W must
    // not exceed HOLD_MAX_W.
    localparam int HOLD_MAX_W = 8;

    typedef struct packed {
        logic                  complete_data;
        logic                  complete_instr;
        logic [IR_W-1:0]       ir;
        logic [NZP_W-1:0]      nzp;
        logic [PSR_W-1:0]      psr;
        logic [IR_W-1:0]       ir_exec;
        logic [IR_W-1:0]       imem_dout;
        logic [HOLD_MAX_W-1:0] hold;
    } control_in_txn_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } drv_state_t;

endpackage

// File: rtl/control_in_drv_fifo.sv
// ---------------------------------------------------------------------------
// control_in_drv_fifo
// DEPTH-entry record FIFO for the control_in transmitter. Writes and pointer
// updates are synchronous; the head entry is presented combinationally so
// the driver can load it on the same edge that pops it.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous, active-high reset (flushes pointers)
//   push     in   write wr_data at posedge (ignored when full)
//   wr_data  in   record to store
//   pop      in   advance read pointer at posedge (ignored when empty)
//   rd_data  out  record at the head of the FIFO
//   full     out  no free entries
//   empty    out  no stored entries
// ---------------------------------------------------------------------------
module control_in_drv_fifo
    import control_in_drv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  control_in_txn_t wr_data,
    input  logic            pop,
    output control_in_txn_t rd_data,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the index
    // bits match.
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            wr_en;
    logic            rd_en;
    control_in_txn_t mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en   = push && !full;
    assign rd_en   = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // NOTE: the storage array has no reset; only the pointers define which
    // entries are valid, so clearing the data would just cost reset routing.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/control_in_driver_rtl.sv
// ---------------------------------------------------------------------------
// control_in_driver_rtl
// Transmitter for the LC3 control_in interface. Records arrive on a
// valid/ready port, are buffered in a FIFO and are driven onto the bus one
// at a time, each held for in_hold+1 cycles. Consecutive records follow
// back-to-back when enable is high and the FIFO is non-empty.
//
// Ports:
//   clock              in   rising-edge clock
//   reset              in   asynchronous, active-high reset
//   enable             in   permits popping new records
//   in_valid           in   record offered
//   in_ready           out  record accepted when in_valid & in_ready at posedge
//   in_complete_data   in   record field
//   in_complete_instr  in   record field
//   in_IR              in   record field (16)
//   in_NZP             in   record field (3)
//   in_psr             in   record field (3)
//   in_IR_Exec         in   record field (16)
//   in_IMem_dout       in   record field (16)
//   in_hold            in   extra cycles to hold the record (0 = one cycle)
//   complete_data      out  bus
//   complete_instr     out  bus
//   IR                 out  bus (16)
//   NZP                out  bus (3)
//   psr                out  bus (3)
//   IR_Exec            out  bus (16)
//   IMem_dout          out  bus (16)
//   busy               out  record active or FIFO non-empty
//   txn_count          out  records fully driven, wraps modulo 2^16
// ---------------------------------------------------------------------------
module control_in_driver_rtl
    import control_in_drv_pkg::*;
#(
    parameter int   DEPTH         = 4,
    parameter int   HOLD_W        = 4,
    parameter logic IDLE_COMPLETE = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_complete_data,
    input  logic              in_complete_instr,
    input  logic [IR_W-1:0]   in_IR,
    input  logic [NZP_W-1:0]  in_NZP,
    input  logic [PSR_W-1:0]  in_psr,
    input  logic [IR_W-1:0]   in_IR_Exec,
    input  logic [IR_W-1:0]   in_IMem_dout,
    input  logic [HOLD_W-1:0] in_hold,
    output logic              complete_data,
    output logic              complete_instr,
    output logic [IR_W-1:0]   IR,
    output logic [NZP_W-1:0]  NZP,
    output logic [PSR_W-1:0]  psr,
    output logic [IR_W-1:0]   IR_Exec,
    output logic [IR_W-1:0]   IMem_dout,
    output logic              busy,
    output logic [15:0]       txn_count
);

    control_in_txn_t   wr_txn;
    control_in_txn_t   head;
    logic              push;
    logic              pop;
    logic              rec_done;
    logic              fifo_full;
    logic              fifo_empty;
    drv_state_t        state;
    drv_state_t        state_nxt;
    logic [HOLD_W-1:0] hold_cnt;

    assign wr_txn = '{
        complete_data:  in_complete_data,
        complete_instr: in_complete_instr,
        ir:             in_IR,
        nzp:            in_NZP,
        psr:            in_psr,
        ir_exec:        in_IR_Exec,
        imem_dout:      in_IMem_dout,
        hold:           HOLD_MAX_W'(in_hold)
    };

    assign push = in_valid && in_ready;

    control_in_drv_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_txn),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch
        // is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (pop)              state_nxt = DRIVE;
            DRIVE:   if (rec_done && !pop) state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs and control strobes
    // ---------------------------------------------------------------
    always_comb begin
        // The last hold cycle of a record is also the edge on which the
        // next record may load, giving back-to-back records with no gap.
        rec_done = (state == DRIVE) && (hold_cnt == '0);
        pop      = enable && !fifo_empty && ((state == IDLE) || (hold_cnt == '0));
        // Gated by reset so the port reads 0 while reset is held, yet is
        // already 1 in the first cycle after release.
        in_ready = !reset && !fifo_full;
        busy     = (state == DRIVE) || !fifo_empty;
    end

    // ---------------------------------------------------------------
    // Bus registers, hold counter, completed-record counter
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            complete_data  <= 1'b0;
            complete_instr <= 1'b0;
            IR             <= '0;
            NZP            <= '0;
            psr            <= '0;
            IR_Exec        <= '0;
            IMem_dout      <= '0;
            hold_cnt       <= '0;
            txn_count      <= '0;
        end else begin
            if (rec_done) txn_count <= txn_count + 16'd1;

            if (pop) begin
                complete_data  <= head.complete_data;
                complete_instr <= head.complete_instr;
                IR             <= head.ir;
                NZP            <= head.nzp;
                psr            <= head.psr;
                IR_Exec        <= head.ir_exec;
                IMem_dout      <= head.imem_dout;
                hold_cnt       <= HOLD_W'(head.hold);
            end else if (rec_done) begin
                // Data fields keep their last values while idle; only the
                // completion strobes return to their idle level.
                complete_data  <= IDLE_COMPLETE;
                complete_instr <= IDLE_COMPLETE;
            end else if (state == DRIVE) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_in_driver_rtl.sv
// ---------------------------------------------------------------------------
// tb_control_in_driver_rtl
// Directed scenarios followed by randomized traffic. A queue-based
// transaction model predicts every bus output after each clock edge.
// ---------------------------------------------------------------------------
module tb_control_in_driver_rtl;

    localparam int DEPTH  = 4;
    localparam int HOLD_W = 4;

    logic              clock;
    logic              reset;
    logic              enable;
    logic              in_valid;
    logic              in_ready;
    logic              in_complete_data;
    logic              in_complete_instr;
    logic [15:0]       in_IR;
    logic [2:0]        in_NZP;
    logic [2:0]        in_psr;
    logic [15:0]       in_IR_Exec;
    logic [15:0]       in_IMem_dout;
    logic [HOLD_W-1:0] in_hold;
    logic              complete_data;
    logic              complete_instr;
    logic [15:0]       IR;
    logic [2:0]        NZP;
    logic [2:0]        psr;
    logic [15:0]       IR_Exec;
    logic [15:0]       IMem_dout;
    logic              busy;
    logic [15:0]       txn_count;

    control_in_driver_rtl #(
        .DEPTH         (DEPTH),
        .HOLD_W        (HOLD_W),
        .IDLE_COMPLETE (1'b1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_complete_data  (in_complete_data),
        .in_complete_instr (in_complete_instr),
        .in_IR             (in_IR),
        .in_NZP            (in_NZP),
        .in_psr            (in_psr),
        .in_IR_Exec        (in_IR_Exec),
        .in_IMem_dout      (in_IMem_dout),
        .in_hold           (in_hold),
        .complete_data     (complete_data),
        .complete_instr    (complete_instr),
        .IR                (IR),
        .NZP               (NZP),
        .psr               (psr),
        .IR_Exec           (IR_Exec),
        .IMem_dout         (IMem_dout),
        .busy              (busy),
        .txn_count         (txn_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        cd;
        logic        ci;
        logic [15:0] ir;
        logic [2:0]  nzp;
        logic [2:0]  psr;
        logic [15:0] ire;
        logic [15:0] imem;
        int          hold;
    } rec_t;

    // Reference model: pending records, the record on the bus, and how many
    // more edges it stays there.
    rec_t        q[$];
    logic        m_cd, m_ci;
    logic [15:0] m_ir, m_ire, m_imem;
    logic [2:0]  m_nzp, m_psr;
    bit          m_active;
    int          m_remaining;
    logic [15:0] m_count;

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [73:0] dut_vec();
        return {complete_data, complete_instr, IR, NZP, psr, IR_Exec, IMem_dout,
                busy, in_ready, txn_count};
    endfunction

    function automatic logic [73:0] model_vec();
        logic exp_busy;
        logic exp_ready;
        exp_busy  = m_active || (q.size() != 0);
        exp_ready = !reset && (q.size() < DEPTH);
        return {m_cd, m_ci, m_ir, m_nzp, m_psr, m_ire, m_imem, exp_busy, exp_ready, m_count};
    endfunction

    task automatic model_reset();
        q.delete();
        m_cd = 0; m_ci = 0; m_ir = '0; m_nzp = '0; m_psr = '0; m_ire = '0; m_imem = '0;
        m_active = 0; m_remaining = 0; m_count = '0;
    endtask

    // Effect of one clock edge given the inputs presented before it.
    task automatic model_edge(input bit en, input bit v, input rec_t r);
        bit   accept;
        bit   ending;
        bit   take;
        rec_t h;
        accept = q.size() < DEPTH;
        ending = m_active && (m_remaining == 0);
        take   = en && (q.size() > 0) && (!m_active || (m_remaining == 0));
        if (ending) m_count = m_count + 16'd1;
        if (take) begin
            h = q.pop_front();
            m_cd = h.cd; m_ci = h.ci; m_ir = h.ir; m_nzp = h.nzp;
            m_psr = h.psr; m_ire = h.ire; m_imem = h.imem;
            m_active = 1; m_remaining = h.hold;
        end else if (ending) begin
            m_active = 0; m_cd = 1'b1; m_ci = 1'b1;
        end else if (m_active) begin
            m_remaining--;
        end
        if (v && accept) q.push_back(r);
    endtask

    function automatic rec_t mk(logic cd, logic ci, logic [15:0] ir, logic [2:0] nzp,
                                logic [2:0] p, logic [15:0] ire, logic [15:0] imem, int hold);
        rec_t r;
        r.cd = cd; r.ci = ci; r.ir = ir; r.nzp = nzp; r.psr = p;
        r.ire = ire; r.imem = imem; r.hold = hold;
        return r;
    endfunction

    function automatic rec_t rand_rec();
        return mk(1'($urandom), 1'($urandom), 16'($urandom), 3'($urandom), 3'($urandom),
                  16'($urandom), 16'($urandom), int'($urandom_range(0, 4)));
    endfunction

    // Present inputs, clock once, then compare the whole output bus.
    task automatic drive(input bit en, input bit v, input rec_t r);
        enable            = en;
        in_valid          = v;
        in_complete_data  = r.cd;
        in_complete_instr = r.ci;
        in_IR             = r.ir;
        in_NZP            = r.nzp;
        in_psr            = r.psr;
        in_IR_Exec        = r.ire;
        in_IMem_dout      = r.imem;
        in_hold           = HOLD_W'(r.hold);
        @(posedge clock);
        model_edge(en, v, r);
        @(negedge clock);
        check("cycle", dut_vec(), model_vec());
    endtask

    task automatic idle_steps(input int n, input bit en);
        rec_t z;
        z = mk(0, 0, '0, '0, '0, '0, '0, 0);
        for (int i = 0; i < n; i++) drive(en, 1'b0, z);
    endtask

    // Reset asserted between edges: outputs must clear with no clock.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("reset_async", dut_vec(), model_vec());
        check("reset_zero", dut_vec(), '0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_release", dut_vec(), model_vec());
        check("ready_after_reset", {in_ready, busy}, 2'b10);
    endtask

    rec_t r1, r2, zr;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        enable      = 1'b0;
        in_valid    = 1'b0;
        zr          = mk(0, 0, '0, '0, '0, '0, '0, 0);
        model_reset();
        @(negedge clock);

        // Single record, hold=2.
        do_reset();
        r1 = mk(1'b0, 1'b1, 16'h1234, 3'b010, 3'b100, 16'h5678, 16'h9ABC, 2);
        drive(1'b1, 1'b1, r1);
        drive(1'b1, 1'b0, zr);
        check("single_load", {complete_data, complete_instr, IR, NZP, psr, IR_Exec, IMem_dout},
              {1'b0, 1'b1, 16'h1234, 3'b010, 3'b100, 16'h5678, 16'h9ABC});
        drive(1'b1, 1'b0, zr);
        drive(1'b1, 1'b0, zr);
        check("single_hold", {complete_data, complete_instr, IR}, {1'b0, 1'b1, 16'h1234});
        drive(1'b1, 1'b0, zr);
        check("single_end", {complete_data, complete_instr, IR, txn_count, busy},
              {1'b1, 1'b1, 16'h1234, 16'd1, 1'b0});

        // Back-to-back records, hold=0.
        do_reset();
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, mk(1'b1, 1'b0, 16'hA000 + 16'(i), 3'(i), 3'(i), 16'h1111, 16'h2222, 0));
        check("b2b_ir", IR, 16'hA001);
        idle_steps(3, 1'b1);
        check("b2b_count", {txn_count, busy}, {16'd3, 1'b0});

        // Full FIFO with enable low.
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, mk(1'b0, 1'b0, 16'hB000 + 16'(i), 3'd1, 3'd2, 16'h3333, 16'h4444, 1));
        check("full_ready", in_ready, 1'b0);
        drive(1'b0, 1'b1, mk(1'b1, 1'b1, 16'hBEEF, 3'd7, 3'd7, 16'hFFFF, 16'hFFFF, 0));
        check("full_reject", {in_ready, busy, txn_count}, {1'b0, 1'b1, 16'd0});
        drive(1'b1, 1'b0, zr);
        check("full_ready_after_pop", {in_ready, IR}, {1'b1, 16'hB000});
        idle_steps(10, 1'b1);
        check("full_drain", {txn_count, IR, busy}, {16'd4, 16'hB003, 1'b0});

        // Enable dropped during a hold=5 record with a second record queued.
        do_reset();
        r1 = mk(1'b1, 1'b0, 16'hC001, 3'd3, 3'd4, 16'h5555, 16'h6666, 5);
        r2 = mk(1'b0, 1'b1, 16'hC002, 3'd5, 3'd6, 16'h7777, 16'h8888, 0);
        drive(1'b1, 1'b1, r1);
        drive(1'b1, 1'b1, r2);
        idle_steps(10, 1'b0);
        check("en_drop_idle", {IR, txn_count, busy, complete_data, complete_instr},
              {16'hC001, 16'd1, 1'b1, 1'b1, 1'b1});
        drive(1'b1, 1'b0, zr);
        check("en_resume", {IR, complete_data, complete_instr}, {16'hC002, 1'b0, 1'b1});
        idle_steps(2, 1'b1);

        // Reset during a hold=7 record with two more queued.
        do_reset();
        drive(1'b1, 1'b1, mk(1'b1, 1'b1, 16'hD000, 3'd1, 3'd1, 16'h0101, 16'h0202, 7));
        drive(1'b1, 1'b1, mk(1'b1, 1'b1, 16'hD001, 3'd2, 3'd2, 16'h0303, 16'h0404, 1));
        drive(1'b1, 1'b1, mk(1'b1, 1'b1, 16'hD002, 3'd3, 3'd3, 16'h0505, 16'h0606, 1));
        idle_steps(2, 1'b1);
        do_reset();
        idle_steps(3, 1'b1);
        check("post_reset_empty", {busy, txn_count, IR}, '0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset();
            else
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6, rand_rec());
        end
        idle_steps(40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
